// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - control and status bundle for clk_div_monitor
interface clk_div_monitor_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clr_err;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err_period;
  logic             err_duty;
  logic             err_stuck;

  modport master (
    output en, clr_err, clk_in,
    input  period, high_time, meas_valid, locked, err_period, err_duty, err_stuck
  );

  modport slave (
    input  en, clr_err, clk_in,
    output period, high_time, meas_valid, locked, err_period, err_duty, err_stuck
  );
endinterface

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period/duty/stuck checker for a divided clock sampled in the source domain
module clk_div_monitor #(
  parameter int EXP_PERIOD = 5,
  parameter int PERIOD_TOL = 0,
  parameter int MIN_HIGH   = 2,
  parameter int MAX_HIGH   = 3,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  clk_div_monitor_if.slave  mon
);

  // Period window kept one bit wider so a tolerance larger than the period cannot wrap.
  localparam logic [CNT_W:0]   PER_LO = (EXP_PERIOD > PERIOD_TOL) ?
                                        (CNT_W+1)'(EXP_PERIOD - PERIOD_TOL) : '0;
  localparam logic [CNT_W:0]   PER_HI = (CNT_W+1)'(EXP_PERIOD + PERIOD_TOL);
  localparam logic [CNT_W-1:0] MIN_H  = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_H  = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_CNT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt, hcnt, good_cnt;
  logic             stuck_q;

  logic             rise;
  logic             per_ok, duty_ok, timeout;
  logic [CNT_W-1:0] cnt_inc, hcnt_inc, good_nxt;

  always_comb begin
    rise     = s2 & ~s3;
    per_ok   = ({1'b0, cnt} >= PER_LO) && ({1'b0, cnt} <= PER_HI);
    duty_ok  = (hcnt >= MIN_H) && (hcnt <= MAX_H);
    // stuck_q keeps a held counter from re-raising err_stuck after clr_err.
    timeout  = (cnt == TMO) && !rise && !stuck_q;
    cnt_inc  = ((cnt == TMO) || (cnt == '1)) ? cnt : cnt + CNT_W'(1);
    hcnt_inc = (hcnt == '1) ? hcnt : hcnt + {{(CNT_W-1){1'b0}}, s2};
    good_nxt = (good_cnt >= LOCK_C) ? LOCK_C : good_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      cnt            <= '0;
      hcnt           <= '0;
      good_cnt       <= '0;
      stuck_q        <= 1'b0;
      mon.period     <= '0;
      mon.high_time  <= '0;
      mon.meas_valid <= 1'b0;
      mon.locked     <= 1'b0;
      mon.err_period <= 1'b0;
      mon.err_duty   <= 1'b0;
      mon.err_stuck  <= 1'b0;
    end else begin
      s1             <= mon.clk_in;
      s2             <= s1;
      s3             <= s2;
      mon.meas_valid <= 1'b0;
      mon.err_period <= mon.err_period & ~mon.clr_err;
      mon.err_duty   <= mon.err_duty & ~mon.clr_err;
      mon.err_stuck  <= mon.err_stuck & ~mon.clr_err;

      if (!mon.en) begin
        state      <= IDLE;
        cnt        <= '0;
        hcnt       <= '0;
        good_cnt   <= '0;
        stuck_q    <= 1'b0;
        mon.locked <= 1'b0;
      end else if (rise) begin
        cnt     <= CNT_W'(1);
        hcnt    <= CNT_W'(1);
        stuck_q <= 1'b0;
        state   <= RUN;
        // The first rise out of IDLE only aligns the counters; nothing is reported.
        if (state == RUN) begin
          mon.period     <= cnt;
          mon.high_time  <= hcnt;
          mon.meas_valid <= 1'b1;
          if (per_ok && duty_ok) begin
            good_cnt   <= good_nxt;
            mon.locked <= (good_nxt >= LOCK_C);
          end else begin
            good_cnt   <= '0;
            mon.locked <= 1'b0;
            if (!per_ok)  mon.err_period <= 1'b1;
            if (!duty_ok) mon.err_duty   <= 1'b1;
          end
        end
      end else begin
        cnt  <= cnt_inc;
        hcnt <= hcnt_inc;
        if (timeout) begin
          mon.err_stuck <= 1'b1;
          mon.locked    <= 1'b0;
          good_cnt      <= '0;
          stuck_q       <= 1'b1;
          state         <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - table-driven scoreboard bench for clk_div_monitor
module tb_clk_div_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clk_div_monitor_if #(.CNT_W(16)) bus ();

  clk_div_monitor #(
    .EXP_PERIOD(5), .PERIOD_TOL(0), .MIN_HIGH(2), .MAX_HIGH(3),
    .LOCK_CNT(4), .TIMEOUT(64), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  always #5 clk = ~clk;

  // One row = one clk_in cycle; expected fields describe its measurement,
  // which the DUT reports at the following rising edge.
  typedef struct {
    int h; int l; bit chk; bit clr;
    int per; int hi; bit lock; bit ep; bit ed;
  } row_t;

  typedef struct {
    int per; int hi; bit lock; bit ep; bit ed; int idx;
  } exp_t;

  row_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int h, input int l, input bit chk, input bit clr,
                     input int per, input int hi, input bit lock, input bit ep, input bit ed);
    row_t r;
    r = '{h, l, chk, clr, per, hi, lock, ep, ed};
    tbl.push_back(r);
  endtask

  task automatic drive_row(input row_t r);
    for (int k = 0; k < r.h; k++) begin
      @(negedge clk);
      bus.clk_in  = 1'b1;
      bus.clr_err = r.clr && (k == 2);
    end
    for (int k = 0; k < r.l; k++) begin
      @(negedge clk);
      bus.clk_in  = 1'b0;
      bus.clr_err = 1'b0;
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].chk) begin
        e = '{tbl[i].per, tbl[i].hi, tbl[i].lock, tbl[i].ep, tbl[i].ed, i};
        sb.push_back(e);
      end
      drive_row(tbl[i]);
    end
  endtask

  // Closes the last table period with a 3-cycle high and checks report latency.
  task automatic trailing_rise(input string nm);
    @(negedge clk); bus.clk_in = 1'b1;
    @(negedge clk);
    @(negedge clk); check({nm, "_early"}, bus.meas_valid, 0);
    @(negedge clk); check({nm, "_lat"}, bus.meas_valid, 1);
    bus.clk_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.meas_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_meas", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("row%0d_period", e.idx), bus.period, e.per);
        check($sformatf("row%0d_high", e.idx), bus.high_time, e.hi);
        check($sformatf("row%0d_locked", e.idx), bus.locked, e.lock);
        check($sformatf("row%0d_err_period", e.idx), bus.err_period, e.ep);
        check($sformatf("row%0d_err_duty", e.idx), bus.err_duty, e.ed);
      end
    end
  end

  initial begin
    int n;
    bit lk63;
    //   h  l chk clr per hi lock ep ed
    for (int i = 0; i < 3; i++) add(3, 2, 1, 0, 5, 3, 0, 0, 0);   // 0-2
    add(3, 2, 1, 0, 5, 3, 1, 0, 0);                              // 3 lock
    add(3, 2, 1, 0, 5, 3, 1, 0, 0);                              // 4
    add(3, 3, 1, 0, 6, 3, 0, 1, 0);                              // 5 long period
    for (int i = 0; i < 3; i++) add(3, 2, 1, 0, 5, 3, 0, 1, 0);   // 6-8
    add(3, 2, 1, 0, 5, 3, 1, 1, 0);                              // 9 relock
    add(4, 1, 1, 0, 5, 4, 0, 1, 1);                              // 10 duty
    add(4, 1, 1, 0, 5, 4, 0, 1, 1);                              // 11
    for (int i = 0; i < 3; i++) add(3, 2, 1, 0, 5, 3, 0, 1, 1);   // 12-14
    add(3, 2, 1, 0, 5, 3, 1, 1, 1);                              // 15
    for (int i = 0; i < 3; i++) add(3, 2, 1, 0, 5, 3, 0, 0, 0);   // 16-18
    add(3, 2, 1, 0, 5, 3, 1, 0, 0);                              // 19
    add(3, 3, 1, 0, 6, 3, 0, 1, 0);                              // 20 bad, clr on its report
    add(3, 2, 1, 1, 5, 3, 0, 1, 0);                              // 21
    add(3, 2, 1, 0, 5, 3, 0, 1, 0);                              // 22
    add(3, 2, 1, 0, 5, 3, 0, 1, 0);                              // 23
    add(3, 2, 1, 0, 5, 3, 1, 1, 0);                              // 24
    add(3, 2, 1, 0, 5, 3, 0, 1, 0);                              // 25
    add(3, 2, 0, 0, 0, 0, 0, 0, 0);                              // 26 cut by reset
    add(3, 2, 1, 0, 5, 3, 0, 0, 0);                              // 27
    add(3, 2, 1, 0, 5, 3, 0, 0, 0);                              // 28

    bus.en = 1'b1; bus.clr_err = 1'b0; bus.clk_in = 1'b0;
    @(negedge clk);
    check("rst_period", bus.period, 0);
    check("rst_high", bus.high_time, 0);
    check("rst_valid", bus.meas_valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_errs", {bus.err_period, bus.err_duty, bus.err_stuck}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_rows(0, 15);
    trailing_rise("r15");

    lk63 = 1'b0;
    n = 0;
    while (!bus.err_stuck && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 63) lk63 = bus.locked;
    end
    check("stuck_delay", n, 64);
    check("stuck_locked_before", lk63, 1);
    check("stuck_locked_after", bus.locked, 0);

    @(negedge clk); bus.clr_err = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0;
    check("clr_alone_errs", {bus.err_period, bus.err_duty, bus.err_stuck}, 0);
    repeat (5) @(negedge clk);
    check("stuck_no_retrigger", bus.err_stuck, 0);

    run_rows(16, 24);
    trailing_rise("r24");

    @(negedge clk); bus.en = 1'b0;
    @(negedge clk);
    check("en_off_locked", bus.locked, 0);
    check("en_off_period", bus.period, 5);
    check("en_off_high", bus.high_time, 3);
    check("en_off_err_period", bus.err_period, 1);
    @(negedge clk); bus.en = 1'b1;

    run_rows(25, 26);
    @(negedge clk); bus.clk_in = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", bus.period, 0);
    check("arst_high", bus.high_time, 0);
    check("arst_flags", {bus.meas_valid, bus.locked, bus.err_period, bus.err_duty, bus.err_stuck}, 0);
    bus.clk_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_rows(27, 28);
    trailing_rise("r28");
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
